fft_result_reader: RTL and testbench

Read-out engine for the FFT result memory, the read side of the 4-bank sample/result RAM that the ADC-load path writes.
- After the FFT core raises its ready flag, a start pulse makes this block sweep the shared read address over all four banks.
- It captures the four real-part words per address and serializes them as one valid/ready sample stream in natural interleaved order: index = 4*addr + bank.
- Sits between fft_top (iADDR_RD_x / oDATA_RE_x) and the downstream consumer (DMA, UART packer or bench monitor).

---
 rtl/fft_result_reader.sv | 97 +++++++++
 tb/tb_fft_result_reader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fft_result_reader.sv
// fft_result_reader: sweeps the 4-bank FFT result RAM and streams the real parts as index 4*addr+bank (define FFT_RD_HALF_SPECTRUM_EN for half sweep)
module fft_result_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic [DATA_W-1:0] iDATA_RE_0,
  input  logic [DATA_W-1:0] iDATA_RE_1,
  input  logic [DATA_W-1:0] iDATA_RE_2,
  input  logic [DATA_W-1:0] iDATA_RE_3,
  output logic [ADDR_W-1:0] oADDR_RD,
  output logic [DATA_W-1:0] oDATA,
  output logic [ADDR_W+1:0] oINDEX,
  output logic              oVALID,
  input  logic              iREADY,
  output logic              oLAST,
  output logic              oBUSY,
  output logic              oDONE
);
  localparam int CW = $clog2(RD_LAT + 2);
`ifdef FFT_RD_HALF_SPECTRUM_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2 ** (ADDR_W - 1) - 1);
`else
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2 ** ADDR_W - 1);
`endif
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [1:0] bank;
  logic [CW-1:0] wcnt;
  logic [DATA_W-1:0] hold [4];
  logic done, start, cap, fire, wrap, fin;
  // next state and per-cycle strobes; a start coinciding with done is dropped
  always_comb begin
    state_nxt = state;
    start = 1'b0;
    cap = 1'b0;
    fire = 1'b0;
    case (state)
      IDLE: begin
        start = iSTART && !done;
        state_nxt = start ? WAIT : IDLE;
      end
      WAIT: begin
        cap = wcnt == CW'(RD_LAT);
        state_nxt = cap ? OUT : WAIT;
      end
      OUT: begin
        fire = iREADY;
        state_nxt = (fire && bank == 2'd3) ? ((addr == LAST_ADDR) ? IDLE : WAIT) : OUT;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign wrap = fire && bank == 2'd3;
  assign fin = wrap && addr == LAST_ADDR;
  // state, address/bank/wait counters and the four-word capture buffer
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state <= IDLE;
      addr <= '0;
      bank <= '0;
      wcnt <= '0;
      done <= 1'b0;
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else begin
      state <= state_nxt;
      done <= fin;
      if (start) begin
        addr <= '0;
        wcnt <= '0;
      end else if (state == WAIT) wcnt <= wcnt + 1'b1;
      if (cap) begin
        hold[0] <= iDATA_RE_0;
        hold[1] <= iDATA_RE_1;
        hold[2] <= iDATA_RE_2;
        hold[3] <= iDATA_RE_3;
        bank <= '0;
      end
      if (fire) bank <= bank + 1'b1;
      if (wrap && !fin) begin
        addr <= addr + 1'b1;
        wcnt <= '0;
      end
    end
  end
  assign oADDR_RD = addr;
  assign oVALID = state == OUT;
  assign oDATA = oVALID ? hold[bank] : '0;
  assign oINDEX = {addr, bank};
  assign oLAST = oVALID && addr == LAST_ADDR && bank == 2'd3;
  assign oBUSY = state != IDLE;
  assign oDONE = done;
endmodule

// File: tb/tb_fft_result_reader.sv
// tb_fft_result_reader: randomized stream checks of fft_result_reader against an array model of the result RAM
module tb_fft_result_reader;
`ifdef FFT_RD_HALF_SPECTRUM_EN
  localparam int NA = 256;
`else
  localparam int NA = 512;
`endif
  localparam int NB = 4 * NA;
  logic clk = 0, rst_n = 0, start = 0, ready = 1;
  logic [15:0] rd0, rd1, rd2, rd3, data;
  logic [8:0] addr_rd;
  logic [10:0] index;
  logic valid, last, busy, done;
  logic [15:0] mem [4][512];
  logic [15:0] exp_q [$];
  int tests = 0, fails = 0, beat_n = 0, done_cnt = 0, busy_cycles = 0, max_addr = 0;
  bit rnd = 0;

  fft_result_reader dut (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start),
    .iDATA_RE_0(rd0), .iDATA_RE_1(rd1), .iDATA_RE_2(rd2), .iDATA_RE_3(rd3),
    .oADDR_RD(addr_rd), .oDATA(data), .oINDEX(index), .oVALID(valid),
    .iREADY(ready), .oLAST(last), .oBUSY(busy), .oDONE(done)
  );

  always #5 clk = ~clk;

  // one-cycle-latency RAM banks
  always @(posedge clk) begin
    rd0 <= mem[0][addr_rd];
    rd1 <= mem[1][addr_rd];
    rd2 <= mem[2][addr_rd];
    rd3 <= mem[3][addr_rd];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void build_exp();
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(mem[i % 4][i / 4]);
  endfunction

  initial forever begin
    @(posedge clk);
    #1 ready = rnd ? 1'($urandom % 2) : 1'b1;
  end

  // stream monitor: every valid cycle must show the expected beat
  always @(negedge clk) begin
    if (done) done_cnt++;
    busy_cycles += int'(busy);
    if (int'(addr_rd) > max_addr) max_addr = int'(addr_rd);
    if (valid) begin
      if (beat_n < NB) begin
        check("data", 32'(data), 32'(exp_q[beat_n]));
        check("index", 32'(index), 32'(beat_n));
        check("last", 32'(last), 32'(beat_n == NB - 1));
      end else check("extra_beat", 32'(valid), 0);
      if (ready) beat_n++;
    end else if (last) check("last_without_valid", 32'(last), 0);
    if (done) check("done_beats", 32'(beat_n), 32'(NB));
  end

  task automatic check_zero();
    check("rst_addr", 32'(addr_rd), 0);
    check("rst_data", 32'(data), 0);
    check("rst_index", 32'(index), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_last", 32'(last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
  endtask

  task automatic run_sweep(input bit r, input int restart_at, input int abort_at);
    int lat, cyc;
    bit pulsed;
    build_exp();
    @(posedge clk);
    #2;
    rnd = r; beat_n = 0; done_cnt = 0; busy_cycles = 0; max_addr = 0; pulsed = 0;
    start = 1;
    @(posedge clk);
    #2 start = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid && lat < 10);
    check("first_valid_latency", 32'(lat), 3);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk);
      #2;
      cyc++;
      start = 0;
      if (restart_at >= 0 && !pulsed && beat_n >= restart_at) begin
        start = 1;
        pulsed = 1;
      end
      if (abort_at >= 0 && beat_n >= abort_at) begin
        rst_n = 0;
        @(posedge clk);
        #2 rst_n = 1;
        check_zero();
        repeat (10) @(negedge clk);
        check("abort_idle_valid", 32'(valid), 0);
        check("abort_idle_busy", 32'(busy), 0);
        check("abort_no_done", 32'(done_cnt), 0);
        return;
      end
    end
    check("done_seen", 32'(done), 1);
    start = 1;
    @(posedge clk);
    #2 start = 0;
    check("start_at_done_ignored", 32'(busy), 0);
    repeat (8) @(negedge clk);
    check("idle_after_done", 32'(valid | busy), 0);
    check("done_once", 32'(done_cnt), 1);
    check("beat_total", 32'(beat_n), 32'(NB));
    check("max_addr", 32'(max_addr), 32'(NA - 1));
    if (!r) check("sweep_cycles", 32'(busy_cycles), 32'(NA * 6));
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 512; j++) mem[b][j] = 16'(4 * j + b);
    repeat (3) @(posedge clk);
    #2 check_zero();
    rst_n = 1;
    run_sweep(0, -1, -1);
    run_sweep(1, -1, -1);
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 512; j++) mem[b][j] = 16'd100;
    mem[3][NA - 1] = 16'h8000;
    run_sweep(1, -1, -1);
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 512; j++) mem[b][j] = 16'($urandom);
    run_sweep(0, 500, -1);
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 512; j++) mem[b][j] = 16'(4 * j + b);
    run_sweep(1, -1, 700);
    run_sweep(0, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
